// File: rtl/store_queue_pkg.sv
// Shared types and helpers for the store queue and its forwarding matcher.
package store_queue_pkg;

  localparam int SQ_DATA_WIDTH = 11;
  localparam int SQ_ADDR_WIDTH = 11;

  // One queued store request at the default widths.
  typedef struct packed {
    logic [SQ_ADDR_WIDTH-1:0] addr;
    logic [SQ_DATA_WIDTH-1:0] data;
  } sq_entry_t;

  // Age of a slot relative to the head: 0 is the oldest entry, larger is younger.
  function automatic int unsigned sq_age(input int unsigned slot,
                                         input int unsigned head,
                                         input int unsigned depth);
    return (slot + depth - head) % depth;
  endfunction

endpackage

// File: rtl/sq_fwd_match.sv
// Combinational store-to-load forwarding: picks the youngest valid entry whose
// address matches the load address.
module sq_fwd_match
  import store_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = SQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = SQ_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic [ADDR_WIDTH-1:0]      addrs [DEPTH],
  input  logic [DATA_WIDTH-1:0]      datas [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  output logic                       hit,
  output logic [DATA_WIDTH-1:0]      data
);

  int unsigned best_age;

  // Scan every slot and keep the matching entry with the greatest age from the head.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    hit      = 1'b0;
    data     = '0;
    best_age = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addrs[i] == ld_addr) &&
          (!hit || (sq_age(i, 32'(rd_ptr), DEPTH) > best_age))) begin
        hit      = 1'b1;
        data     = datas[i];
        best_age = sq_age(i, 32'(rd_ptr), DEPTH);
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// FIFO of pending stores between the accumulator and data memory, with
// forwarding of the newest pending data to loads that hit a queued address.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DATA_WIDTH = SQ_DATA_WIDTH,
  parameter int ADDR_WIDTH = SQ_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_WIDTH-1:0]    st_addr,
  input  logic [DATA_WIDTH-1:0]    st_data,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [DATA_WIDTH-1:0]    mem_wr_data,
  input  logic                     mem_wr_ack,
  input  logic [ADDR_WIDTH-1:0]    ld_addr,
  output logic                     ld_fwd_hit,
  output logic [DATA_WIDTH-1:0]    ld_fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int            PW    = $clog2(DEPTH);
  localparam logic [PW:0]   FULL  = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT1  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR1  = PW'(1);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic                  push;
  logic                  pop;

  // Full/empty come from count alone, so ready never depends on the memory ack.
  assign st_ready    = (count != FULL);
  assign mem_wr_en   = (count != '0);
  assign empty       = (count == '0);
  assign push        = st_valid & st_ready;
  assign pop         = mem_wr_en & mem_wr_ack;
  assign mem_wr_addr = mem_wr_en ? addr_mem[rd_ptr] : '0;
  assign mem_wr_data = mem_wr_en ? data_mem[rd_ptr] : '0;

  // Pointer and occupancy update; reset drops every pending store.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR1;
      if (pop)  rd_ptr <= rd_ptr + PTR1;
      unique case ({push, pop})
        2'b10:   count <= count + CNT1;
        2'b01:   count <= count - CNT1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage written on every accepted store.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; stale slots are masked by count, which keeps this a plain RAM.
    if (push) begin
      addr_mem[wr_ptr] <= st_addr;
      data_mem[wr_ptr] <= st_data;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (sq_age(i, 32'(rd_ptr), DEPTH) < 32'(count));
    end
  end

  sq_fwd_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fwd (
    .addrs   (addr_mem),
    .datas   (data_mem),
    .valid   (valid),
    .rd_ptr  (rd_ptr),
    .ld_addr (ld_addr),
    .hit     (ld_fwd_hit),
    .data    (ld_fwd_data)
  );

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int AW    = SQ_ADDR_WIDTH;
  localparam int DW    = SQ_DATA_WIDTH;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_ack = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_fwd_hit;
  logic [DW-1:0] ld_fwd_data;
  logic [$clog2(DEPTH):0] count;
  logic          empty;

  always #5 clk = ~clk;

  store_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ack  (mem_wr_ack),
    .ld_addr     (ld_addr),
    .ld_fwd_hit  (ld_fwd_hit),
    .ld_fwd_data (ld_fwd_data),
    .count       (count),
    .empty       (empty)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= DEPTH);
  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_wr_en && !mem_wr_ack) |=> ($stable(mem_wr_addr) && $stable(mem_wr_data)));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(st_valid && st_ready && (count == DEPTH)));

  int        n_cmp = 0;
  int        n_bad = 0;
  sq_entry_t model_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every output with what the pending-store list implies.
  task automatic check_model();
    logic          hit;
    logic [DW-1:0] fd;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    hit = 1'b0;
    fd  = '0;
    ha  = '0;
    hd  = '0;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].addr == ld_addr) begin
        hit = 1'b1;
        fd  = model_q[i].data;
        break;
      end
    end
    if (model_q.size() != 0) begin
      ha = model_q[0].addr;
      hd = model_q[0].data;
    end
    check("st_ready",    st_ready,    model_q.size() < DEPTH);
    check("mem_wr_en",   mem_wr_en,   model_q.size() != 0);
    check("mem_wr_addr", mem_wr_addr, ha);
    check("mem_wr_data", mem_wr_data, hd);
    check("count",       count,       model_q.size());
    check("empty",       empty,       model_q.size() == 0);
    check("fwd_hit",     ld_fwd_hit,  hit);
    check("fwd_data",    ld_fwd_data, fd);
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input logic r, input logic v, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic ack, input logic [AW-1:0] ld);
    bit do_push, do_pop;
    @(negedge clk);
    rst        = r;
    st_valid   = v;
    st_addr    = a;
    st_data    = d;
    mem_wr_ack = ack;
    ld_addr    = ld;
    #1;
    check_model();
    do_push = !r && v && (model_q.size() < DEPTH);
    do_pop  = !r && ack && (model_q.size() != 0);
    @(posedge clk);
    if (r) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back('{addr: a, data: d});
    end
    #1;
    rst        = 1'b0;
    st_valid   = 1'b0;
    mem_wr_ack = 1'b0;
  endtask

  initial begin
    logic          r, v, ack;
    logic [AW-1:0] a, ld;
    logic [DW-1:0] d;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle.
    step(0, 0, '0, '0, 0, 11'h000);
    check("rst_ready", st_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_count", count, 0);
    check("rst_hit",   ld_fwd_hit, 0);

    // Single store, held three cycles, then acked.
    step(0, 1, 11'h010, 11'h049, 0, 11'h000);
    for (int i = 0; i < 3; i++) begin
      check("lat_en",   mem_wr_en, 1);
      check("lat_addr", mem_wr_addr, 11'h010);
      check("lat_data", mem_wr_data, 11'h049);
      step(0, 0, '0, '0, 0, 11'h000);
    end
    step(0, 0, '0, '0, 1, 11'h000);
    check("lat_empty", empty, 1);

    // Fill, refuse an extra store, drain in order.
    for (int i = 0; i < 4; i++) step(0, 1, AW'(1 + i), DW'(11'h064 + i), 0, 11'h000);
    check("full_count", count, 4);
    check("full_ready", st_ready, 0);
    step(0, 1, 11'h7FF, 11'h7FF, 0, 11'h000);
    check("full_refused", count, 4);
    for (int i = 0; i < 4; i++) begin
      check("drain_addr", mem_wr_addr, 1 + i);
      check("drain_data", mem_wr_data, 11'h064 + i);
      step(0, 0, '0, '0, 1, 11'h000);
    end
    check("drain_empty", empty, 1);

    // Forwarding picks the youngest match.
    step(0, 1, 11'h020, 11'h100, 0, 11'h000);
    step(0, 1, 11'h021, 11'h200, 0, 11'h000);
    step(0, 1, 11'h020, 11'h749, 0, 11'h000);
    ld_addr = 11'h020;
    #1;
    check("fwd_young_hit",  ld_fwd_hit, 1);
    check("fwd_young_data", ld_fwd_data, 11'h749);
    ld_addr = 11'h022;
    #1;
    check("fwd_miss_hit",  ld_fwd_hit, 0);
    check("fwd_miss_data", ld_fwd_data, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 1, 11'h020);

    // Streaming push+ack every cycle across pointer wrap.
    step(0, 1, 11'h100, 11'h500, 0, 11'h100);
    for (int i = 1; i < 10; i++) begin
      step(0, 1, AW'(11'h100 + i), DW'(11'h500 + i), 1, AW'(11'h100 + i));
      check("stream_count", count, 1);
      check("stream_addr",  mem_wr_addr, 11'h100 + i);
    end
    step(0, 0, '0, '0, 1, 11'h000);
    check("stream_empty", empty, 1);

    // Reset mid-operation discards pending stores.
    for (int i = 0; i < 3; i++) step(0, 1, AW'(11'h300 + i), DW'(11'h0A0 + i), 0, 11'h000);
    check("pre_rst_count", count, 3);
    step(1, 0, '0, '0, 0, 11'h300);
    check("mid_rst_count", count, 0);
    check("mid_rst_wr_en", mem_wr_en, 0);
    check("mid_rst_ready", st_ready, 1);
    ld_addr = 11'h300;
    #1;
    check("mid_rst_hit", ld_fwd_hit, 0);

    // Random traffic against the model, alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 79) == 0);
      v   = ($urandom_range(0, 3) != 0);
      ack = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      a   = AW'($urandom_range(0, 7));
      d   = DW'($urandom);
      ld  = AW'($urandom_range(0, 7));
      step(r, v, a, d, ack, ld);
    end
    step(0, 0, '0, '0, 0, 11'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
